// File: rtl/demux_scan_driver_pkg.sv
// Shared definitions for the demux scan driver: channel count, select
// width, FSM state encoding and a small bit-pick helper.
package demux_defs;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  // Two-state FSM encoding, kept as plain constants for legacy tools.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Bit of the captured word that belongs on the demux data pin for a slot.
  function automatic logic slot_bit(input logic [NUM_CH-1:0] word,
                                    input logic [SEL_W-1:0]  idx);
    return word[idx];
  endfunction

endpackage

// File: rtl/demux_scan_driver_if.sv
// Handshake and demux pin bundle between a word producer and the scan driver.
interface demux_scan_driver_if;
  import demux_defs::*;

  logic [NUM_CH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic              en;
  logic              i1;
  logic              s2;
  logic              s1;
  logic              s0;
  logic              busy;
  logic              done;

  // Producer side: offers words, may cancel, watches the demux pins.
  modport master (
    output in_data, in_valid, abort,
    input  in_ready, en, i1, s2, s1, s0, busy, done
  );

  // Scan driver side.
  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, en, i1, s2, s1, s0, busy, done
  );

endinterface

// File: rtl/demux_scan_driver_slot_timer.sv
// Per-slot hold counter: counts 0..HOLD_CYCLES-1 while running and flags
// the last cycle of a slot with tc. clr parks the count at zero.
module slot_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt;

  assign tc = (cnt == TC_VAL);

  // Hold counter: cleared outside a scan, wraps to zero at each slot end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (run) begin
      cnt <= tc ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/demux_scan_driver.sv
// Scan driver for a 1x8 demux: takes one word over valid/ready, then walks
// the select lines 0..7 presenting word bit k on I1 while select = k.
// All demux pins come straight from registers so select and data switch on
// the same edge.
module demux_scan_driver
  import demux_defs::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_scan_driver_if.slave   bus
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

  logic [0:0]        state;
  logic [NUM_CH-1:0] data_p0;
  logic [SEL_W-1:0]  slot_p0;
  logic [SEL_W-1:0]  sel_p0;
  logic              en_p0;
  logic              i1_p0;
  logic              busy_p0;
  logic              done_p0;

  logic              take;
  logic              tc;
  logic [SEL_W-1:0]  slot_nxt;

  assign bus.in_ready = (state == ST_IDLE) & ~bus.abort;
  assign take         = bus.in_valid & bus.in_ready;
  assign slot_nxt     = slot_p0 + SEL_W'(1);

  assign bus.en   = en_p0;
  assign bus.i1   = i1_p0;
  assign bus.s2   = sel_p0[2];
  assign bus.s1   = sel_p0[1];
  assign bus.s0   = sel_p0[0];
  assign bus.busy = busy_p0;
  assign bus.done = done_p0;

  // The hold counter only runs during a scan; an abort restarts it too.
  slot_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_slot_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == ST_IDLE) | bus.abort),
    .run   (state == ST_SCAN),
    .tc    (tc)
  );

  // FSM, slot index, captured word and registered demux pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      data_p0 <= '0;
      slot_p0 <= '0;
      sel_p0  <= '0;
      en_p0   <= 1'b0;
      i1_p0   <= 1'b0;
      busy_p0 <= 1'b0;
      done_p0 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_p0 <= 1'b0;
          if (take) begin
            state   <= ST_SCAN;
            data_p0 <= bus.in_data;
            slot_p0 <= '0;
            sel_p0  <= '0;
            en_p0   <= 1'b1;
            i1_p0   <= slot_bit(bus.in_data, '0);
            busy_p0 <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (bus.abort) begin
            // Cancel wins over everything, including the final slot end.
            state   <= ST_IDLE;
            slot_p0 <= '0;
            sel_p0  <= '0;
            en_p0   <= 1'b0;
            i1_p0   <= 1'b0;
            busy_p0 <= 1'b0;
            done_p0 <= 1'b0;
          end else if (tc) begin
            if (slot_p0 == LAST_SLOT) begin
              state   <= ST_IDLE;
              slot_p0 <= '0;
              sel_p0  <= '0;
              en_p0   <= 1'b0;
              i1_p0   <= 1'b0;
              busy_p0 <= 1'b0;
              done_p0 <= 1'b1;
            end else begin
              slot_p0 <= slot_nxt;
              sel_p0  <= slot_nxt;
              i1_p0   <= slot_bit(data_p0, slot_nxt);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          slot_p0 <= '0;
          sel_p0  <= '0;
          en_p0   <= 1'b0;
          i1_p0   <= 1'b0;
          busy_p0 <= 1'b0;
          done_p0 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scan_driver.sv
// Bench for demux_scan_driver: two instances (hold 1 and hold 3) checked
// every cycle against a time-based model of the scan.
module tb_demux_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  demux_scan_driver_if bus1 ();
  demux_scan_driver_if bus3 ();

  demux_scan_driver #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  demux_scan_driver #(.HOLD_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int errors = 0;
  int checks = 0;

  // Model: a scan is "cycles elapsed since capture"; slot = elapsed / hold.
  int         hold [2] = '{1, 3};
  bit         m_busy [2];
  bit         m_done [2];
  logic [7:0] m_word [2];
  int         m_t [2];

  int en_cnt [2];
  int done_cnt [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_word[i] = 8'h00; m_t[i] = 0;
    end
  endfunction

  function automatic void model_edge(input int i, input bit valid, input logic [7:0] data, input bit abort);
    if (m_busy[i]) begin
      if (abort) begin
        m_busy[i] = 0; m_done[i] = 0;
      end else if (m_t[i] == 8 * hold[i] - 1) begin
        m_busy[i] = 0; m_done[i] = 1;
      end else begin
        m_t[i]++; m_done[i] = 0;
      end
    end else begin
      m_done[i] = 0;
      if (valid && !abort) begin
        m_busy[i] = 1; m_word[i] = data; m_t[i] = 0;
      end
    end
  endfunction

  // Packed expectation {in_ready, busy, done, en, i1, sel[2:0]}.
  function automatic logic [7:0] expect_vec(input int i, input bit abort);
    int sel;
    bit i1;
    sel = m_busy[i] ? m_t[i] / hold[i] : 0;
    i1  = m_busy[i] ? m_word[i][sel] : 1'b0;
    return {~m_busy[i] & ~abort, m_busy[i], m_done[i], m_busy[i], i1, 3'(sel)};
  endfunction

  task automatic check_both(input string tag);
    check({tag, "_h1"}, {24'd0, bus1.in_ready, bus1.busy, bus1.done, bus1.en, bus1.i1,
                         bus1.s2, bus1.s1, bus1.s0}, {24'd0, expect_vec(0, bus1.abort)});
    check({tag, "_h3"}, {24'd0, bus3.in_ready, bus3.busy, bus3.done, bus3.en, bus3.i1,
                         bus3.s2, bus3.s1, bus3.s0}, {24'd0, expect_vec(1, bus3.abort)});
  endtask

  // One clock: model follows the inputs seen at the edge, then outputs checked.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_edge(0, bus1.in_valid, bus1.in_data, bus1.abort);
      model_edge(1, bus3.in_valid, bus3.in_data, bus3.abort);
    end
    #1;
    check_both(tag);
    en_cnt[0] += int'(bus1.en);   en_cnt[1] += int'(bus3.en);
    done_cnt[0] += int'(bus1.done); done_cnt[1] += int'(bus3.done);
  endtask

  task automatic clear_counts();
    en_cnt = '{0, 0};
    done_cnt = '{0, 0};
  endtask

  initial begin
    bus1.in_data = 8'h00; bus1.in_valid = 1'b0; bus1.abort = 1'b0;
    bus3.in_data = 8'h00; bus3.in_valid = 1'b0; bus3.abort = 1'b0;
    model_reset();
    clear_counts();

    // Reset state
    #2;
    check_both("reset");
    step("reset_hold");
    step("reset_hold");
    #3 rst_n = 1'b1;
    step("post_reset");

    // Single word A5 at hold 1, FF at hold 3
    bus1.in_data = 8'hA5; bus1.in_valid = 1'b1;
    bus3.in_data = 8'hFF; bus3.in_valid = 1'b1;
    clear_counts();
    step("capture");
    bus1.in_valid = 1'b0; bus3.in_valid = 1'b0;
    for (int c = 0; c < 30; c++) step("scan1");
    check("en_cycles_h1", en_cnt[0], 8);
    check("en_cycles_h3", en_cnt[1], 24);
    check("done_pulses_h1", done_cnt[0], 1);
    check("done_pulses_h3", done_cnt[1], 1);

    // Back-to-back words 01 then 80 on hold 1 with valid held high
    bus1.in_data = 8'h01; bus1.in_valid = 1'b1;
    step("b2b_cap1");
    bus1.in_data = 8'h80;
    for (int c = 0; c < 8; c++) step("b2b_scan1");
    check("b2b_done_ready", {30'd0, bus1.done, bus1.in_ready}, 32'd3);
    step("b2b_cap2");
    bus1.in_valid = 1'b0;
    check("b2b_no_gap", {31'd0, bus1.busy}, 32'd1);
    for (int c = 0; c < 10; c++) step("b2b_scan2");

    // Abort during slot 3 of F0 on hold 1
    bus1.in_data = 8'hF0; bus1.in_valid = 1'b1;
    step("abort_cap");
    bus1.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) step("abort_scan");
    check("abort_slot3", {29'd0, bus1.s2, bus1.s1, bus1.s0}, 32'd3);
    bus1.abort = 1'b1;
    clear_counts();
    step("abort_edge");
    bus1.abort = 1'b0;
    #1;
    check("abort_idle", {28'd0, bus1.en, bus1.busy, bus1.in_ready, bus1.s0 | bus1.s1 | bus1.s2}, 32'b0010);
    for (int c = 0; c < 10; c++) step("abort_after");
    check("abort_no_done", done_cnt[0], 0);

    // Asynchronous reset in the middle of slot 5 on hold 3
    bus3.in_data = 8'($urandom) | 8'h20; bus3.in_valid = 1'b1;
    step("rst_cap");
    bus3.in_valid = 1'b0;
    for (int c = 0; c < 16; c++) step("rst_scan");
    check("rst_slot5", {29'd0, bus3.s2, bus3.s1, bus3.s0}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_both("rst_async");
    #2 rst_n = 1'b1;
    clear_counts();
    for (int c = 0; c < 10; c++) step("rst_quiet");
    check("rst_no_activity", en_cnt[0] + en_cnt[1] + done_cnt[0] + done_cnt[1], 0);

    // Valid with abort in idle: blocked, then captured once abort drops
    bus1.in_data = 8'h3C; bus1.in_valid = 1'b1; bus1.abort = 1'b1;
    bus3.in_data = 8'hC3; bus3.in_valid = 1'b1; bus3.abort = 1'b1;
    for (int c = 0; c < 3; c++) step("idle_abort");
    check("idle_abort_ready", {30'd0, bus1.in_ready, bus3.in_ready}, 32'd0);
    bus1.abort = 1'b0; bus3.abort = 1'b0;
    step("idle_release");
    check("idle_release_busy", {30'd0, bus1.busy, bus3.busy}, 32'd3);
    bus1.in_valid = 1'b0; bus3.in_valid = 1'b0;
    for (int c = 0; c < 30; c++) step("idle_scan");

    // Randomised traffic
    for (int c = 0; c < 800; c++) begin
      bus1.in_data  = 8'($urandom);
      bus1.in_valid = ($urandom_range(0, 2) == 0);
      bus1.abort    = ($urandom_range(0, 19) == 0);
      bus3.in_data  = 8'($urandom);
      bus3.in_valid = ($urandom_range(0, 2) == 0);
      bus3.abort    = ($urandom_range(0, 29) == 0);
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_scan_driver.md
Name: demux_scan_driver

Overview:
Upstream stage that feeds the 1x8 demultiplexer. It accepts one 8-bit word through a valid/ready handshake. It then scans the demux select lines through channels 0..7, presenting word bit k on the demux data input while select = k, so demux output m(k+1) receives bit k. It drives the demux EN, I1, S2, S1 and S0 pins directly from registers and pulses DONE when the scan completes.

Parameters:
HOLD_CYCLES, 1, clock cycles each select slot is held; legal range 1..255.
NUM_CH, 8, channels scanned; fixed at 8 and matched to the 3 select bits.

Ports:
CLK  input  1  single clock, rising edge
RST_N  input  1  asynchronous active-low reset
IN_DATA  input  8  word to scan out; bit k goes to channel k
IN_VALID  input  1  IN_DATA is valid
IN_READY  output  1  block can accept a word this cycle
ABORT  input  1  synchronous scan cancel
EN  output  1  demux enable, registered
I1  output  1  demux data input, registered
S2  output  1  demux select MSB, registered
S1  output  1  demux select bit 1, registered
S0  output  1  demux select LSB, registered
BUSY  output  1  scan in progress
DONE  output  1  one-cycle pulse when a scan completes normally

Behaviour:
- Interface: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values, applied while RST_N = 0 regardless of CLK:
  - state = IDLE.
  - EN = 0; I1 = 0; {S2,S1,S0} = 0.
  - BUSY = 0; DONE = 0.
  - data register = 0; slot index = 0; hold counter = 0.
- IN_READY is combinational: IN_READY = (state == IDLE) & ~ABORT.
- States: IDLE and SCAN, two states only. DONE is a registered flag, not a separate state.
- IDLE:
  - Outputs held at EN = 0, I1 = 0, S = 0, BUSY = 0.
  - Transfer occurs on the rising edge where IN_VALID & IN_READY are both high.
  - On that edge: capture IN_DATA, set slot k = 0 and hold counter = 0, and go to SCAN.
  - From the next cycle: EN = 1, {S2,S1,S0} = 0, I1 = IN_DATA[0], BUSY = 1.
  - IN_VALID without IN_READY: no capture, no state change.
- SCAN, cycle level:
  - Each slot holds EN = 1, {S2,S1,S0} = k, I1 = data[k] for exactly HOLD_CYCLES cycles.
  - The hold counter counts 0..HOLD_CYCLES-1. At terminal count, k increments and the next slot's outputs appear on the following cycle.
  - The slot index is 3 bits. It never wraps inside a scan; slot 7 at terminal count ends the scan.
- Normal end:
  - On the edge after slot 7's last cycle: state = IDLE, EN = 0, S = 0, I1 = 0, BUSY = 0, DONE = 1 for exactly that one cycle.
  - IN_READY is already 1 in the DONE cycle, so back-to-back words are allowed.
  - EN is high for exactly 8*HOLD_CYCLES consecutive cycles per word.
- Latency: transfer at edge t → slot 0 visible from edge t+1 → DONE visible from edge t+1+8*HOLD_CYCLES.
- ABORT:
  - In SCAN: next edge forces IDLE with all outputs at idle values. DONE stays 0 and the remaining slots are discarded.
  - In IDLE: blocks capture via IN_READY; otherwise no effect.
  - ABORT and terminal count of slot 7 on the same edge: ABORT wins, no DONE.
- IN_VALID during SCAN is ignored. The word is not captured and must be held by the producer until IN_READY.
- RST_N asserted mid-scan: immediate return to reset values with no DONE. After release, the block waits in IDLE for a new handshake.
- Outputs change only on the CLK rising edge (except on reset). Select and data change together, so there is no glitch window between them.

Decomposition:
- Shared package demux_defs holds:
  - constants NUM_CH = 8 and SEL_W = 3;
  - state encoding localparams ST_IDLE = 1'b0 and ST_SCAN = 1'b1.
- One sub-module is natural: slot_timer.
  - Contents: 8-bit hold counter with clear and terminal-count output `tc`, parameterised by HOLD_CYCLES.
  - The top level keeps the FSM, slot index, data register and output registers.

Test Plan:
1. Reset then IN_DATA = 8'hA5, IN_VALID one cycle, HOLD_CYCLES = 1 → (S, I1) per cycle = (0,1) (1,0) (2,1) (3,0) (4,0) (5,1) (6,0) (7,1); EN high 8 cycles; DONE one pulse on cycle 9; demux m1..m8 = 1,0,1,0,0,1,0,1 in turn.
2. HOLD_CYCLES = 3, IN_DATA = 8'hFF → each select value held 3 cycles, I1 = 1 throughout, EN high 24 cycles, DONE at cycle 25.
3. Back-to-back words 8'h01 then 8'h80, with IN_VALID held high → second handshake occurs in the DONE cycle; no idle gap; second scan has I1 = 1 only at S = 7.
4. ABORT asserted during slot 3 of word 8'hF0 → next cycle EN = 0, S = 0, BUSY = 0, DONE never asserts, IN_READY = 1.
5. RST_N pulled low mid-slot 5 (asynchronously, between edges) → EN, S, I1, BUSY drop to 0 immediately; after release no output activity until a new IN_VALID.
6. IN_VALID held high with ABORT high in IDLE → IN_READY = 0, no capture; deasserting ABORT → capture on that edge.
